multicycle_main_ctrl: RTL and testbench

// - Main control FSM of the multi-cycle MIPS CPU. Steps each instruction through fetch/decode/execute/mem/writeback.
// - Drives datapath mux selects and write strobes. Produces the 2-bit ALUOp consumed by the ALU decoder.
// - ALUOp encoding: 00 = add, 01 = sub, 10 = decode by Funct. 11 is never driven.
// - Sits between the instruction register (Op field) and the datapath/ALU decoder.

---
 rtl/multicycle_main_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_main_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_main_ctrl
//   Main control FSM of the multi-cycle MIPS CPU. Steps each instruction
//   through fetch / decode / execute / memory / writeback, drives the datapath
//   mux selects and write strobes, and produces the 2-bit ALUOp for the ALU
//   decoder (00 = add, 01 = sub, 10 = decode by Funct).
//
//   Optional feature: define MCCTRL_BNE_EN to add the BNE state (12).
//   Without it, OP_BNE is treated as an illegal opcode.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   Op        in   IR[31:26], stable from DECODE until return to FETCH
//   Zero      in   ALU zero flag
//   MemReady  in   memory access complete this cycle
//   IorD      out  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite  out  memory write strobe
//   IRWrite   out  instruction register load
//   RegDst    out  register destination (1 = rd, 0 = rt)
//   MemtoReg  out  register write data (1 = MDR, 0 = ALUOut)
//   RegWrite  out  register file write
//   ALUSrcA   out  ALU A select (0 = PC, 1 = regA)
//   ALUSrcB   out  ALU B select (00 regB, 01 4, 10 SignImm, 11 SignImm<<2)
//   ALUOp     out  ALU operation class
//   PCSrc     out  PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   PCEn      out  PC load enable
//   IllegalOp out  one-cycle pulse on an unsupported opcode in DECODE
//   State     out  current state (debug)
// -----------------------------------------------------------------------------
module multicycle_main_ctrl #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_J     = 6'b000010,
   parameter logic [5:0] OP_BNE   = 6'b000101
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Op,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic       IllegalOp,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
`ifdef MCCTRL_BNE_EN
      ,
      S_BNE     = 4'd12
`endif
   } state_t;

   // Moore control word; 'fetch' marks states whose IRWrite/PCWrite follow MemReady
   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       fetch;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
      logic       branchne;
   } ctrl_t;

   state_t r_state;
   ctrl_t  r_ctrl;
   state_t w_next;
   logic   w_illegal;
   ctrl_t  w_ctrl;

   function automatic ctrl_t decode(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_DECODE:  c.alusrcb = 2'b11;
         S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         S_MEMRD:   c.iord = 1'b1;
         S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
         S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
         S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
         S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
         S_BRANCH:  begin
            c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1;
         end
         S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
         S_ADDIWB:  c.regwrite = 1'b1;
         S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
`ifdef MCCTRL_BNE_EN
         S_BNE:     begin
            c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branchne = 1'b1;
         end
`endif
         // FETCH and the unused encodings share the fetch decode
         default:   begin c.fetch = 1'b1; c.alusrcb = 2'b01; end
      endcase
      return c;
   endfunction

   always_comb begin
      w_next    = r_state;
      w_illegal = 1'b0;
      case (r_state)
         S_FETCH:   if (MemReady) w_next = S_DECODE;
         S_DECODE:  begin
            case (Op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_EXECUTE;
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JUMP;
`ifdef MCCTRL_BNE_EN
               OP_BNE:       w_next = S_BNE;
`else
               OP_BNE:       begin w_next = S_FETCH; w_illegal = 1'b1; end
`endif
               default:      begin w_next = S_FETCH; w_illegal = 1'b1; end
            endcase
         end
         S_MEMADR:  w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   if (MemReady) w_next = S_MEMWB;
         S_MEMWR:   if (MemReady) w_next = S_FETCH;
         S_EXECUTE: w_next = S_ALUWB;
         S_ADDIEX:  w_next = S_ADDIWB;
         default:   w_next = S_FETCH;
      endcase
   end

   // Control word is registered from the next-state decode, so it always
   // matches r_state; its reset value is the FETCH decode for the same reason.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_ctrl  <= decode(S_FETCH);
      end else begin
         r_state <= w_next;
         r_ctrl  <= decode(w_next);
      end
   end

   // Gating by rst_n drops every strobe the instant reset asserts
   assign w_ctrl    = rst_n ? r_ctrl : '0;

   assign IorD      = w_ctrl.iord;
   assign MemWrite  = w_ctrl.memwrite;
   assign IRWrite   = w_ctrl.fetch & MemReady;
   assign RegDst    = w_ctrl.regdst;
   assign MemtoReg  = w_ctrl.memtoreg;
   assign RegWrite  = w_ctrl.regwrite;
   assign ALUSrcA   = w_ctrl.alusrca;
   assign ALUSrcB   = w_ctrl.alusrcb;
   assign ALUOp     = w_ctrl.aluop;
   assign PCSrc     = w_ctrl.pcsrc;
   assign PCEn      = (w_ctrl.fetch & MemReady) | w_ctrl.pcwrite |
                      (w_ctrl.branch & Zero) | (w_ctrl.branchne & ~Zero);
   assign IllegalOp = rst_n & w_illegal;
   assign State     = r_state;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
module tb_multicycle_main_ctrl;

   localparam logic [5:0] T_RTYPE = 6'b000000;
   localparam logic [5:0] T_LW    = 6'b100011;
   localparam logic [5:0] T_SW    = 6'b101011;
   localparam logic [5:0] T_BEQ   = 6'b000100;
   localparam logic [5:0] T_ADDI  = 6'b001000;
   localparam logic [5:0] T_J     = 6'b000010;
   localparam logic [5:0] T_BNE   = 6'b000101;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] Op = '0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSrc;
   logic       PCEn, IllegalOp;
   logic [3:0] State;
   logic [14:0] obs;

   int unsigned total = 0;
   int unsigned bad   = 0;

   multicycle_main_ctrl dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .MemReady(MemReady),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
      .IllegalOp(IllegalOp), .State(State)
   );

   always #5 clk = ~clk;

   assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp};

   function automatic bit is_legal(input logic [5:0] op);
      bit ok;
      ok = (op == T_RTYPE) || (op == T_LW) || (op == T_SW) || (op == T_BEQ) ||
           (op == T_ADDI) || (op == T_J);
`ifdef MCCTRL_BNE_EN
      ok = ok || (op == T_BNE);
`endif
      return ok;
   endfunction

   // Expected cycles per instruction with MemReady held high
   function automatic int unsigned latency(input logic [5:0] op);
      if (op == T_LW) return 5;
      if (op == T_SW || op == T_RTYPE || op == T_ADDI) return 4;
      if (op == T_J || op == T_BEQ) return 3;
`ifdef MCCTRL_BNE_EN
      if (op == T_BNE) return 3;
`endif
      return 2;
   endfunction

   // Output table of each state, packed in the same order as obs
   function automatic logic [14:0] exp_out(input int unsigned st, input bit mr,
                                           input bit z, input bit ill);
      logic iord, memw, irw, rdst, m2r, rw, sa, pcen;
      logic [1:0] sb, aop, psrc;
      {iord, memw, irw, rdst, m2r, rw, sa, pcen} = '0;
      sb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         1:  sb = 2'b11;
         2:  begin sa = 1; sb = 2'b10; end
         3:  iord = 1;
         4:  begin m2r = 1; rw = 1; end
         5:  begin iord = 1; memw = 1; end
         6:  begin sa = 1; aop = 2'b10; end
         7:  begin rdst = 1; rw = 1; end
         8:  begin sa = 1; aop = 2'b01; psrc = 2'b01; pcen = z; end
         9:  begin sa = 1; sb = 2'b10; end
         10: rw = 1;
         11: begin psrc = 2'b10; pcen = 1; end
`ifdef MCCTRL_BNE_EN
         12: begin sa = 1; aop = 2'b01; psrc = 2'b01; pcen = !z; end
`endif
         default: begin sb = 2'b01; irw = mr; pcen = mr; end
      endcase
      return {iord, memw, irw, rdst, m2r, rw, sa, sb, aop, psrc, pcen,
              (st == 1) ? ill : 1'b0};
   endfunction

   // Runs one instruction from FETCH, checking State and outputs every cycle.
   // zmode: 0 = Zero low, 1 = Zero high, 2 = random each cycle.
   task automatic run_instr(input logic [5:0] op, input int unsigned mr_pct,
                            input int unsigned zmode, output int unsigned cycles);
      int unsigned path[$];
      int unsigned idx;
      int unsigned st;
      logic [14:0] e;
      path = {0, 1};
      if (op == T_LW)         path = {0, 1, 2, 3, 4};
      else if (op == T_SW)    path = {0, 1, 2, 5};
      else if (op == T_RTYPE) path = {0, 1, 6, 7};
      else if (op == T_BEQ)   path = {0, 1, 8};
      else if (op == T_ADDI)  path = {0, 1, 9, 10};
      else if (op == T_J)     path = {0, 1, 11};
`ifdef MCCTRL_BNE_EN
      else if (op == T_BNE)   path = {0, 1, 12};
`endif
      idx = 0;
      cycles = 0;
      while (idx < path.size()) begin
         @(negedge clk);
         Op = op;
         MemReady = ($urandom_range(99) < mr_pct);
         Zero = (zmode == 2) ? 1'($urandom_range(1)) : (zmode == 1);
         #1;
         st = path[idx];
         e = exp_out(st, MemReady, Zero, !is_legal(op));
         total++;
         if (State !== 4'(st) || obs !== e) begin
            bad++;
            $display("FAIL op%b_st%0d: State=%0d outs=%b required State=%0d outs=%b",
                     op, st, State, obs, st, e);
         end
         cycles++;
         if (!((st == 0 || st == 3 || st == 5) && !MemReady)) idx++;
         if (cycles > 200) begin
            total++; bad++;
            $display("FAIL timeout op%b: cycles=%0d required <=200", op, cycles);
            idx = path.size();
         end
      end
   endtask

   task automatic test_reset();
      int unsigned n;
      rst_n = 0; MemReady = 1; Op = T_SW;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (State !== 4'd0 || obs !== '0) begin
         bad++;
         $display("FAIL reset_hold: State=%0d outs=%b required 0 / 0", State, obs);
      end
      rst_n = 1; MemReady = 0;
      #1;
      total++;
      if (State !== 4'd0 || obs !== exp_out(0, 0, 0, 0)) begin
         bad++;
         $display("FAIL reset_release: State=%0d outs=%b required 0 / %b",
                  State, obs, exp_out(0, 0, 0, 0));
      end
      // Walk an SW into MEMWR, then pull reset there
      MemReady = 1;
      n = 0;
      while (n < 12) begin
         @(negedge clk);
         if (State == 4'd5) break;
         n++;
      end
      MemReady = 0;
      #1;
      total++;
      if (State !== 4'd5 || MemWrite !== 1'b1) begin
         bad++;
         $display("FAIL memwr_entry: State=%0d MemWrite=%b required 5 / 1", State, MemWrite);
      end
      rst_n = 0;
      #1;
      total++;
      if (State !== 4'd0 || obs !== '0) begin
         bad++;
         $display("FAIL reset_midwrite: State=%0d outs=%b required 0 / 0", State, obs);
      end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      #1;
      total++;
      if (State !== 4'd0 || MemWrite !== 1'b0 || obs !== exp_out(0, 0, 0, 0)) begin
         bad++;
         $display("FAIL after_reset: State=%0d MemWrite=%b outs=%b required 0 / 0 / %b",
                  State, MemWrite, obs, exp_out(0, 0, 0, 0));
      end
   endtask

   task automatic test_lw_stall();
      int unsigned c;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         Op = T_LW; MemReady = 0;
         #1;
         total++;
         if (State !== 4'd0 || IRWrite !== 1'b0 || PCEn !== 1'b0) begin
            bad++;
            $display("FAIL lw_stall%0d: State=%0d IRWrite=%b PCEn=%b required 0 / 0 / 0",
                     i, State, IRWrite, PCEn);
         end
      end
      run_instr(T_LW, 100, 2, c);
      total++;
      if (c !== 5) begin
         bad++;
         $display("FAIL lw_len: cycles=%0d required 5", c);
      end
   endtask

   task automatic test_latency();
      logic [5:0] ops [8];
      int unsigned c;
      ops = '{T_J, T_BEQ, T_RTYPE, T_ADDI, T_SW, T_LW, T_BNE, 6'b111111};
      foreach (ops[i]) begin
         run_instr(ops[i], 100, 2, c);
         total++;
         if (c !== latency(ops[i])) begin
            bad++;
            $display("FAIL latency_op%b: cycles=%0d required %0d", ops[i], c, latency(ops[i]));
         end
      end
   endtask

   task automatic test_branch();
      int unsigned c;
      run_instr(T_BEQ, 100, 1, c);
      run_instr(T_BEQ, 100, 0, c);
      run_instr(T_BNE, 100, 0, c);
      run_instr(T_BNE, 100, 1, c);
      run_instr(T_J, 100, 0, c);
   endtask

   task automatic test_random();
      logic [5:0] legal [7];
      logic [5:0] op;
      int unsigned c;
      legal = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_ADDI, T_J, T_BNE};
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(4) == 0) op = 6'($urandom_range(63));
         else op = legal[$urandom_range(6)];
         run_instr(op, $urandom_range(30, 100), 2, c);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned c;
      int unsigned sum;
      sum = 0;
      run_instr(T_LW, 100, 2, c);    sum += c;
      run_instr(T_SW, 100, 2, c);    sum += c;
      run_instr(T_RTYPE, 100, 2, c); sum += c;
      total++;
      if (sum !== 13) begin
         bad++;
         $display("FAIL back_to_back: cycles=%0d required 13", sum);
      end
   endtask

   initial begin
      test_reset();
      test_lw_stall();
      test_latency();
      test_branch();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
